// File: rtl/slave_rd_arbiter.sv
// Round-robin arbiter sharing the slave RAM read port among NREQ burst readers.
// Issues one address per cycle; returned bytes are steered by a latency tag pipe.
module slave_rd_arbiter #(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 2,
    parameter int AW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_len,
    output logic [NREQ-1:0]   grant,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_last,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              ram_rd_rq,
    output logic [AW-1:0]     rd_addr,
    input  logic [7:0]        slv_data
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   gidx_reg;
    logic [8:0]      issue_cnt_reg;
    logic            pipe_v_reg [RD_LAT];
    logic            pipe_l_reg [RD_LAT];

    logic [AW-1:0]   addr_arr [NREQ];
    logic [8:0]      len_arr  [NREQ];
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic            tail_v;
    logic            tail_last;

    // A length byte of zero encodes a full 256-byte burst.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign len_arr[gi]  = (req_len[gi*8 +: 8] == 8'd0) ? 9'd256
                                                               : {1'b0, req_len[gi*8 +: 8]};
        end
    endgenerate

    // Scan downwards so the requester closest to ptr_reg wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr_reg) + i) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = PW'((int'(ptr_reg) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            gidx_reg      <= '0;
            issue_cnt_reg <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            ram_rd_rq     <= 1'b0;
            rd_addr       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant         <= NREQ'(1) << pick_idx;
                        gidx_reg      <= pick_idx;
                        rd_addr       <= addr_arr[pick_idx];
                        issue_cnt_reg <= len_arr[pick_idx];
                        ram_rd_rq     <= 1'b1;
                        busy          <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_cnt_reg == 9'd1) begin
                        ram_rd_rq <= 1'b0;
                        state_reg <= S_DRAIN;
                    end else begin
                        issue_cnt_reg <= issue_cnt_reg - 9'd1;
                        rd_addr       <= rd_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (tail_last) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    grant     <= '0;
                    busy      <= 1'b0;
                    ptr_reg   <= (gidx_reg == PW'(NREQ - 1)) ? '0 : gidx_reg + PW'(1);
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Tags travel alongside each issued address so captures never depend on state.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_v_reg[gi] <= 1'b0;
                    pipe_l_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    pipe_v_reg[gi] <= ram_rd_rq;
                    pipe_l_reg[gi] <= ram_rd_rq && (issue_cnt_reg == 9'd1);
                end else begin
                    pipe_v_reg[gi] <= pipe_v_reg[(gi == 0) ? 0 : gi - 1];
                    pipe_l_reg[gi] <= pipe_l_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign tail_v    = pipe_v_reg[RD_LAT-1];
    assign tail_last = pipe_v_reg[RD_LAT-1] & pipe_l_reg[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            done      <= '0;
        end else begin
            rsp_valid <= tail_v;
            if (tail_v) begin
                rsp_data <= slv_data;
            end
            rsp_last <= tail_last;
            done     <= tail_last ? grant : '0;
        end
    end

endmodule
